// File: rtl/btn_evt_pkg.sv
// Shared encodings for the button event controller: event types and hold FSM states.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10
    } evt_type_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } hold_state_e;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// Pop on empty is ignored; push while full is accepted only alongside a pop.
module btn_evt_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_c  = (count_q == '0);
        full_c   = (count_q == CNT_W'(DEPTH));
        do_pop   = pop & ~empty_c;
        do_push  = push & (~full_c | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced button levels -> PRESS/RELEASE/LONG events, one pending slot per button,
// round-robin arbitration into an event FIFO read over valid/ready.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned N_BTN          = 2,
    parameter int unsigned LONG_PRESS_CYC = 50000000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BTN-1:0]              btn_db,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(N_BTN)-1:0]      evt_id,
    output logic [1:0]                    evt_type,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int unsigned ID_W  = $clog2(N_BTN);
    localparam int unsigned CNT_W = $clog2(LONG_PRESS_CYC);
    localparam int unsigned EVT_W = ID_W + 2;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);

    logic [N_BTN-1:0]  prev_q, prev_d, rise, fall;
    hold_state_e       state_q [N_BTN];
    hold_state_e       state_d [N_BTN];
    logic [CNT_W-1:0]  cnt_q   [N_BTN];
    logic [CNT_W-1:0]  cnt_d   [N_BTN];
    logic [N_BTN-1:0]  raise;
    evt_type_e         raise_type [N_BTN];

    logic [N_BTN-1:0]  pend_vld_q, pend_vld_d;
    evt_type_e         pend_type_q [N_BTN];
    evt_type_e         pend_type_d [N_BTN];

    logic [ID_W-1:0]   rr_q, rr_d, grant_idx;
    logic [N_BTN-1:0]  grant;
    logic              grant_any;
    int unsigned       idx, nxt;

    logic              ovf_q, ovf_d, drop;
    logic              fifo_full_c, fifo_empty_c, can_push;
    logic [EVT_W-1:0]  head_c;

    // Per-button hold FSMs
    always_comb begin
        prev_d = btn_db;
        rise   = btn_db & ~prev_q;
        fall   = ~btn_db & prev_q;
        raise  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            raise_type[i] = EVT_PRESS;
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        raise[i]   = 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall[i]) begin
                        state_d[i]    = IDLE;
                        raise[i]      = 1'b1;
                        raise_type[i] = EVT_RELEASE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        if (cnt_d[i] == LONG_LAST) begin
                            state_d[i]    = LONG_HELD;
                            raise[i]      = 1'b1;
                            raise_type[i] = EVT_LONG;
                        end
                    end
                end
                LONG_HELD: begin
                    if (fall[i]) begin
                        state_d[i]    = IDLE;
                        raise[i]      = 1'b1;
                        raise_type[i] = EVT_RELEASE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Round-robin grant of one pending slot whenever the FIFO can take a push
    always_comb begin
        can_push  = ~fifo_full_c | (evt_ready & ~fifo_empty_c);
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        idx       = 0;
        nxt       = 0;
        rr_d      = rr_q;
        if (can_push) begin
            for (int unsigned off = 0; off < N_BTN; off++) begin
                idx = 32'(rr_q) + off;
                if (idx >= N_BTN) idx = idx - N_BTN;
                if (!grant_any && pend_vld_q[ID_W'(idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
            nxt  = 32'(grant_idx) + 1;
            rr_d = (nxt >= N_BTN) ? '0 : ID_W'(nxt);
        end
    end

    // Pending slots: a granted slot frees up in time to take this cycle's event
    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            pend_vld_d[i]  = pend_vld_q[i] & ~grant[i];
            pend_type_d[i] = pend_type_q[i];
            if (raise[i]) begin
                if (pend_vld_q[i] && !grant[i]) begin
                    drop = 1'b1;
                end else begin
                    pend_vld_d[i]  = 1'b1;
                    pend_type_d[i] = raise_type[i];
                end
            end
        end
        ovf_d = (ovf_q & ~clr_ovf) | drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            pend_vld_q <= '0;
            rr_q       <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= IDLE;
                cnt_q[i]       <= '0;
                pend_type_q[i] <= EVT_PRESS;
            end
        end else begin
            prev_q      <= prev_d;
            pend_vld_q  <= pend_vld_d;
            rr_q        <= rr_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_type_q <= pend_type_d;
        end
    end

    btn_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_any),
        .push_data ({grant_idx, pend_type_q[grant_idx]}),
        .pop       (evt_ready),
        .rd_data_c (head_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Head fields are forced to zero while empty so stale storage never shows
    assign evt_valid = ~fifo_empty_c;
    assign evt_id    = fifo_empty_c ? '0 : head_c[EVT_W-1:2];
    assign evt_type  = fifo_empty_c ? 2'b00 : head_c[1:0];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: a queue-based reference model predicts the
// event stream, occupancy and overflow; a negedge monitor compares against the DUT.
module tb_button_event_ctrl;

    localparam int N = 2;
    localparam int L = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn_db;
    logic       evt_valid, evt_ready, overflow, clr_ovf;
    logic [0:0] evt_id;
    logic [1:0] evt_type;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    button_event_ctrl #(
        .N_BTN          (N),
        .LONG_PRESS_CYC (L),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_db     (btn_db),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .evt_type   (evt_type),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int id; int t; } ev_t;
    ev_t exp_q[$];

    bit m_prev [N];
    int m_hold [N];
    bit m_pv   [N];
    int m_pt   [N];
    int m_rr, m_cnt;
    bit m_ovf;
    bit mpop, mcan, mgany, mdrop, mr, lv;
    int mg, mt, mi;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_hold[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
            end
            m_rr = 0; m_cnt = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            mpop  = (m_cnt != 0) && evt_ready;
            mcan  = (m_cnt < D) || mpop;
            mgany = 0; mg = 0;
            if (mcan) begin
                for (int o = 0; o < N; o++) begin
                    mi = (m_rr + o) % N;
                    if (!mgany && m_pv[mi]) begin mgany = 1; mg = mi; end
                end
            end
            if (mgany) begin
                exp_q.push_back('{mg, m_pt[mg]});
                m_pv[mg] = 0;
                m_rr = (mg + 1) % N;
            end
            m_cnt = m_cnt + (mgany ? 1 : 0) - (mpop ? 1 : 0);
            mdrop = 0;
            for (int i = 0; i < N; i++) begin
                lv = btn_db[i];
                mr = 0; mt = 0;
                if (lv && !m_prev[i]) begin
                    mr = 1; mt = 0; m_hold[i] = 1;
                end else if (!lv && m_prev[i]) begin
                    mr = 1; mt = 1;
                end else if (lv) begin
                    m_hold[i]++;
                    if (m_hold[i] == L) begin mr = 1; mt = 2; end
                end
                if (mr) begin
                    if (m_pv[i]) mdrop = 1;
                    else begin m_pv[i] = 1; m_pt[i] = mt; end
                end
                m_prev[i] = lv;
            end
            m_ovf = (m_ovf && !clr_ovf) || mdrop;
        end
    end

    // ---------------- monitor ----------------
    ev_t got;
    always @(negedge clk) begin
        check("fifo_count", int'(fifo_count), m_cnt);
        check("overflow", int'(overflow), int'(m_ovf));
        check("evt_valid", int'(evt_valid), (m_cnt != 0) ? 1 : 0);
        if (!reset) begin
            check("reset_evt_id", int'(evt_id), 0);
            check("reset_evt_type", int'(evt_type), 0);
        end else if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                got = exp_q.pop_front();
                check("evt_id", int'(evt_id), got.id);
                check("evt_type", int'(evt_type), got.t);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] b, input logic rdy, input logic clr);
        btn_db    = b;
        evt_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n, input logic [1:0] b, input logic rdy);
        for (int i = 0; i < n; i++) step(b, rdy, 1'b0);
    endtask

    logic [1:0] rb;

    initial begin
        reset = 1'b0; btn_db = 2'b00; evt_ready = 1'b1; clr_ovf = 1'b0;
        @(posedge clk); #2;
        // Held in reset while buttons toggle
        step(2'b01, 1, 0); step(2'b10, 1, 0); step(2'b11, 1, 0); step(2'b00, 1, 0);
        reset = 1'b1;
        steps(4, 2'b00, 1);

        // Short press on button 0
        steps(3, 2'b01, 1);
        steps(5, 2'b00, 1);

        // Long press on button 1
        steps(20, 2'b10, 1);
        steps(5, 2'b00, 1);

        // Simultaneous press and release
        steps(4, 2'b11, 1);
        steps(5, 2'b00, 1);

        // Backpressure fills FIFO, then a drop on button 0
        step(2'b01, 0, 0); step(2'b00, 0, 0); step(2'b10, 0, 0);
        steps(3, 2'b00, 0);
        check("bp_fifo_full", int'(fifo_count), 4);
        check("bp_no_ovf", int'(overflow), 0);
        step(2'b01, 0, 0); steps(2, 2'b00, 0);
        check("bp_fifo_still_full", int'(fifo_count), 4);
        check("bp_ovf_set", int'(overflow), 1);
        steps(8, 2'b00, 1);
        check("bp_drained", int'(fifo_count), 0);
        step(2'b00, 1, 1);
        step(2'b00, 1, 0);
        check("ovf_cleared", int'(overflow), 0);

        // Reset in the middle of a long hold, button kept down
        steps(4, 2'b10, 1);
        reset = 1'b0;
        #1;
        check("midreset_valid", int'(evt_valid), 0);
        check("midreset_count", int'(fifo_count), 0);
        #1;
        steps(2, 2'b10, 1);
        reset = 1'b1;
        steps(12, 2'b10, 1);
        steps(4, 2'b00, 1);

        // Randomised levels, ready and clear
        rb = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) rb[b] = ~rb[b];
            step(rb, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        steps(20, 2'b00, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
